// File: rtl/serial_rx.sv
// Serial frame receiver: start bit, eight data bits LSB first, stop bit.
// The line is sampled mid-bit against a clock-count bit period.
module serial_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       SERIAL_IN,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int          HALF   = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_C = 16'(HALF);
  localparam logic [15:0] LAST_C = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, rx_s_q, samp_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;

  // Start detection uses rx_s; bit sampling uses rx_s one cycle later so the
  // sample edges line up with the bit that started the frame, even at one bit
  // per clock.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      samp_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      sh_q        <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= SERIAL_IN;
      rx_s_q      <= sync1_q;
      samp_q      <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = 16'd0;
        end
      end
      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = 16'd0;
          if (!samp_q) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_C) begin
          sh_d  = {samp_q, sh_q[7:1]};
          cnt_d = 16'd0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d = 16'd0;
          if (samp_q) begin
            rx_data_d  = sh_q;
            rx_valid_d = 1'b1;
            // A start bit already on rx_s is taken without an idle cycle.
            state_d    = rx_s_q ? IDLE : START;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: one instance at 16 clocks per bit and one at
// one clock per bit, with a negedge monitor logging output pulses per cycle.
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       rst16_n = 1'b0;
  logic       rst1_n = 1'b0;
  logic       ser16 = 1'b1;
  logic       ser1 = 1'b1;
  logic [7:0] d16, d1;
  logic       v16, v1, fe16, fe1, b16, b1;
  logic       b16_prev = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int rise16 = -1;
  int fall16 = -1;
  int vcyc16[$];
  int vdat16[$];
  int fecyc16[$];
  int vcyc1[$];
  int vdat1[$];
  int fecyc1[$];

  serial_rx #(.CLKS_PER_BIT(16)) dut16 (
    .CLK(clk), .CLR_N(rst16_n), .SERIAL_IN(ser16),
    .RX_DATA(d16), .RX_VALID(v16), .FRAME_ERR(fe16), .BUSY(b16)
  );

  serial_rx #(.CLKS_PER_BIT(1)) dut1 (
    .CLK(clk), .CLR_N(rst1_n), .SERIAL_IN(ser1),
    .RX_DATA(d1), .RX_VALID(v1), .FRAME_ERR(fe1), .BUSY(b1)
  );

  initial forever #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v16) begin
      vcyc16.push_back(cyc);
      vdat16.push_back(int'(d16));
      $display("[%0d] dut16 RX_VALID data=%02h", cyc, d16);
    end
    if (fe16) begin
      fecyc16.push_back(cyc);
      $display("[%0d] dut16 FRAME_ERR", cyc);
    end
    if (v1) begin
      vcyc1.push_back(cyc);
      vdat1.push_back(int'(d1));
      $display("[%0d] dut1 RX_VALID data=%02h", cyc, d1);
    end
    if (fe1) begin
      fecyc1.push_back(cyc);
      $display("[%0d] dut1 FRAME_ERR", cyc);
    end
    if (b16 && !b16_prev) rise16 <= cyc;
    if (!b16 && b16_prev) fall16 <= cyc;
    b16_prev <= b16;
  end

  task automatic clear_logs();
    vcyc16.delete(); vdat16.delete(); fecyc16.delete();
    vcyc1.delete(); vdat1.delete(); fecyc1.delete();
  endtask

  // Each drive task starts and ends 1 ns after a rising edge.
  task automatic hold16(input logic b, input int n);
    ser16 = b;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame16(input logic [7:0] data, input logic stop);
    hold16(1'b0, 16);
    for (int i = 0; i < 8; i++) hold16(data[i], 16);
    hold16(stop, 16);
  endtask

  task automatic frame1(input logic [7:0] data);
    ser1 = 1'b0; @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin ser1 = data[i]; @(posedge clk); #1; end
    ser1 = 1'b1; @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (d16 !== 8'h00) $display("FAIL reset_data16: got %02h want 00", d16); else n_pass++;
    n_checks++; if (v16 !== 1'b0) $display("FAIL reset_valid16: got %b want 0", v16); else n_pass++;
    n_checks++; if (fe16 !== 1'b0) $display("FAIL reset_ferr16: got %b want 0", fe16); else n_pass++;
    n_checks++; if (b16 !== 1'b0) $display("FAIL reset_busy16: got %b want 0", b16); else n_pass++;
    n_checks++; if (b1 !== 1'b0 || d1 !== 8'h00) $display("FAIL reset_dut1: got busy=%b data=%02h want 0/00", b1, d1); else n_pass++;
    #10;
    rst16_n = 1'b1;
    rst1_n  = 1'b1;
    @(posedge clk); #1;
    hold16(1'b1, 4);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int t0;
    clear_logs();
    t0 = cyc + 1;
    frame16(8'h0B, 1'b1);
    hold16(1'b1, 20);
    n_checks++; if (vcyc16.size() != 1) $display("FAIL basic_count: got %0d pulses want 1", vcyc16.size()); else n_pass++;
    n_checks++; if (vcyc16.size() < 1 || vcyc16[0] != t0 + 155) $display("FAIL basic_timing: got %0d want %0d", (vcyc16.size() > 0) ? vcyc16[0] : -1, t0 + 155); else n_pass++;
    n_checks++; if (vdat16.size() < 1 || vdat16[0] != 'h0B) $display("FAIL basic_data: got %02h want 0b", (vdat16.size() > 0) ? vdat16[0] : -1); else n_pass++;
    n_checks++; if (fecyc16.size() != 0) $display("FAIL basic_ferr: got %0d pulses want 0", fecyc16.size()); else n_pass++;
    n_checks++; if (rise16 != t0 + 2) $display("FAIL basic_busy_rise: got %0d want %0d", rise16, t0 + 2); else n_pass++;
    n_checks++; if (fall16 != t0 + 155) $display("FAIL basic_busy_fall: got %0d want %0d", fall16, t0 + 155); else n_pass++;
    n_checks++; if (d16 !== 8'h0B) $display("FAIL basic_hold: got %02h want 0b", d16); else n_pass++;
    $display("test_basic done");
  endtask

  task automatic test_back_to_back();
    int t0;
    int exp_d[3];
    exp_d[0] = 'h0B; exp_d[1] = 'hFF; exp_d[2] = 'h00;
    clear_logs();
    t0 = cyc + 1;
    frame1(8'h0B);
    frame1(8'hFF);
    frame1(8'h00);
    repeat (10) begin @(posedge clk); #1; end
    n_checks++; if (vcyc1.size() != 3) $display("FAIL b2b_count: got %0d pulses want 3", vcyc1.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (vcyc1.size() <= k || vcyc1[k] != t0 + 12 + 10 * k)
        $display("FAIL b2b_timing%0d: got %0d want %0d", k, (vcyc1.size() > k) ? vcyc1[k] : -1, t0 + 12 + 10 * k);
      else n_pass++;
      n_checks++;
      if (vdat1.size() <= k || vdat1[k] != exp_d[k])
        $display("FAIL b2b_data%0d: got %02h want %02h", k, (vdat1.size() > k) ? vdat1[k] : -1, exp_d[k]);
      else n_pass++;
    end
    n_checks++; if (fecyc1.size() != 0) $display("FAIL b2b_ferr: got %0d pulses want 0", fecyc1.size()); else n_pass++;
    n_checks++; if (b1 !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", b1); else n_pass++;
    $display("test_back_to_back done");
  endtask

  task automatic test_glitch();
    int t0;
    clear_logs();
    t0 = cyc + 1;
    hold16(1'b0, 5);
    hold16(1'b1, 30);
    n_checks++; if (vcyc16.size() != 0 || fecyc16.size() != 0) $display("FAIL glitch_pulse: got valid=%0d ferr=%0d want 0/0", vcyc16.size(), fecyc16.size()); else n_pass++;
    n_checks++; if (fall16 != t0 + 11) $display("FAIL glitch_busy_fall: got %0d want %0d", fall16, t0 + 11); else n_pass++;
    n_checks++; if (d16 !== 8'h0B) $display("FAIL glitch_data_kept: got %02h want 0b", d16); else n_pass++;
    clear_logs();
    t0 = cyc + 1;
    frame16(8'hA5, 1'b1);
    hold16(1'b1, 20);
    n_checks++; if (vdat16.size() != 1 || vdat16[0] != 'hA5) $display("FAIL glitch_next_data: got n=%0d d=%02h want 1/a5", vdat16.size(), (vdat16.size() > 0) ? vdat16[0] : -1); else n_pass++;
    n_checks++; if (vcyc16.size() < 1 || vcyc16[0] != t0 + 155) $display("FAIL glitch_next_timing: got %0d want %0d", (vcyc16.size() > 0) ? vcyc16[0] : -1, t0 + 155); else n_pass++;
    $display("test_glitch done");
  endtask

  task automatic test_frame_err();
    int t0;
    clear_logs();
    t0 = cyc + 1;
    frame16(8'h3C, 1'b0);
    hold16(1'b0, 100);
    n_checks++; if (fecyc16.size() != 1) $display("FAIL ferr_count: got %0d pulses want 1", fecyc16.size()); else n_pass++;
    n_checks++; if (fecyc16.size() < 1 || fecyc16[0] != t0 + 155) $display("FAIL ferr_timing: got %0d want %0d", (fecyc16.size() > 0) ? fecyc16[0] : -1, t0 + 155); else n_pass++;
    n_checks++; if (vcyc16.size() != 0) $display("FAIL ferr_no_valid: got %0d pulses want 0", vcyc16.size()); else n_pass++;
    n_checks++; if (d16 !== 8'hA5) $display("FAIL ferr_data_kept: got %02h want a5", d16); else n_pass++;
    n_checks++; if (b16 !== 1'b1) $display("FAIL ferr_busy_low_line: got %b want 1", b16); else n_pass++;
    hold16(1'b1, 6);
    n_checks++; if (b16 !== 1'b0) $display("FAIL ferr_busy_release: got %b want 0", b16); else n_pass++;
    hold16(1'b1, 10);
    clear_logs();
    frame16(8'h55, 1'b1);
    hold16(1'b1, 20);
    n_checks++; if (vdat16.size() != 1 || vdat16[0] != 'h55) $display("FAIL ferr_next_data: got n=%0d d=%02h want 1/55", vdat16.size(), (vdat16.size() > 0) ? vdat16[0] : -1); else n_pass++;
    n_checks++; if (fecyc16.size() != 0) $display("FAIL ferr_next_ferr: got %0d pulses want 0", fecyc16.size()); else n_pass++;
    $display("test_frame_err done");
  endtask

  task automatic test_reset_mid();
    int t0;
    clear_logs();
    hold16(1'b0, 16);
    for (int i = 0; i < 4; i++) hold16(1'b1, 16);
    hold16(1'b0, 8);
    n_checks++; if (b16 !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", b16); else n_pass++;
    #10;
    rst16_n = 1'b0;
    #1;
    n_checks++; if (d16 !== 8'h00) $display("FAIL rstmid_data: got %02h want 00", d16); else n_pass++;
    n_checks++; if (b16 !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", b16); else n_pass++;
    n_checks++; if (v16 !== 1'b0 || fe16 !== 1'b0) $display("FAIL rstmid_pulses: got valid=%b ferr=%b want 0/0", v16, fe16); else n_pass++;
    @(posedge clk); #1;
    hold16(1'b0, 7);
    for (int i = 0; i < 3; i++) hold16(1'b1, 16);
    hold16(1'b1, 20);
    #10;
    rst16_n = 1'b1;
    @(posedge clk); #1;
    hold16(1'b1, 10);
    t0 = cyc + 1;
    frame16(8'hC3, 1'b1);
    hold16(1'b1, 20);
    n_checks++; if (vdat16.size() != 1 || vdat16[0] != 'hC3) $display("FAIL rstmid_next_data: got n=%0d d=%02h want 1/c3", vdat16.size(), (vdat16.size() > 0) ? vdat16[0] : -1); else n_pass++;
    n_checks++; if (vcyc16.size() < 1 || vcyc16[0] != t0 + 155) $display("FAIL rstmid_next_timing: got %0d want %0d", (vcyc16.size() > 0) ? vcyc16[0] : -1, t0 + 155); else n_pass++;
    n_checks++; if (fecyc16.size() != 0) $display("FAIL rstmid_ferr: got %0d pulses want 0", fecyc16.size()); else n_pass++;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
